memory_bus_arbiter: RTL and testbench
=====================================

Name: memory_bus_arbiter

Overview:
Shares the single core memory port of the Controller between two requesters of a Harvard-style core: port 0 is instruction fetch, port 1 is data load/store. The block accepts held read/write strobes from each requester and grants one at a time. It registers the address, write data and operation, drives the downstream bus until the memory responds, then returns read data plus a one-cycle response pulse to the granted requester. It also carries a timeout watchdog, so a hung memory cannot stall the core forever.

Parameters:
BUS_WIDTH, 32, width of address and data buses
PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, data port (1) wins
TIMEOUT_CYCLES, 1024, cycles spent waiting for memory_response before the transaction is aborted (must be >= 2)
ERROR_DATA, 32'hDEADBEEF, read data returned on a timed-out read

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
inst_read  input  1  port 0 read strobe, held until inst_response
inst_address  input  BUS_WIDTH  port 0 address
inst_read_data  output  BUS_WIDTH  port 0 returned data
inst_response  output  1  port 0 one-cycle completion pulse
data_read  input  1  port 1 read strobe, held until data_response
data_write  input  1  port 1 write strobe, held until data_response
data_address  input  BUS_WIDTH  port 1 address
data_write_data  input  BUS_WIDTH  port 1 write data
data_read_data  output  BUS_WIDTH  port 1 returned data
data_response  output  1  port 1 one-cycle completion pulse
memory_read  output  1  downstream read strobe
memory_write  output  1  downstream write strobe
memory_address  output  BUS_WIDTH  downstream address
memory_write_data  output  BUS_WIDTH  downstream write data
memory_read_data  input  BUS_WIDTH  downstream read data, valid with memory_response
memory_response  input  1  downstream one-cycle completion pulse
bus_error  output  1  one-cycle pulse on timeout abort
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Asynchronous, active-high; clears all state regardless of activity, and any in-flight transaction is dropped with no response.
  - FSM goes to IDLE. All outputs are 0, including both read_data buses and the downstream address/data.
  - last_grant resets to 1, so in round-robin mode port 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESPOND.
- IDLE:
  - A port is requesting if its read or write strobe is high.
  - Single requester: grant that port.
  - Both requesting: in round-robin mode grant the port that is not last_grant; in fixed mode grant port 1.
  - On grant, at the clock edge: latch address, write data (port 1 only) and operation; update last_grant; clear the timeout counter; go to ISSUE.
  - Operation encoding: inst_read gives a read. For port 1, write has precedence if data_read and data_write are both high.
- ISSUE:
  - memory_read/memory_write are driven from registers and held constant, together with memory_address/memory_write_data, for the whole state.
  - Downstream strobes first rise one cycle after the grant edge.
  - On memory_response: latch memory_read_data into the granted port's read_data register (reads only; writes leave it unchanged), drop the strobes and go to RESPOND.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without a response: drop the strobes, load ERROR_DATA for a read, pulse bus_error, and go to RESPOND.
- RESPOND:
  - Exactly one cycle. The granted port's response output is 1; the other port's response stays 0. Then go to IDLE.
- Read data stability: read_data stays stable until that port's next completed read.
- Requester contract: requesters sample the response at the same edge that ends RESPOND and deassert or change their strobe for the next cycle. The arbiter never re-grants from RESPOND.
- Latency, grant in cycle N with the downstream answering on the first strobe cycle: strobe high in N+1, memory_response in N+1, response pulse in N+2. Minimum throughput is one transaction per 3 cycles.
- memory_response outside ISSUE is ignored.
- Requests that arrive during ISSUE/RESPOND wait in place; no request is lost while its strobe is held.
- A requester changing its address while it is waiting has no effect on a transaction already granted.
- busy = (state != IDLE).

Test Plan:
- Single fetch: inst_read=1, inst_address=0x100; memory answers 0x00000013 one cycle after memory_read rises -> memory_address=0x100; inst_read_data=0x00000013 with inst_response pulsing once; data_response stays 0.
- Data write: data_write=1, address 0x2000, data 0xCAFEBABE -> memory_write=1 with those values, memory_read=0; data_response pulses once; data_read_data unchanged.
- Round-robin tie: both ports request continuously, PRIORITY_MODE=0 -> grants alternate 0,1,0,1, starting with port 0 after reset.
- Fixed priority: PRIORITY_MODE=1 with both ports requesting for 4 transactions -> all 4 go to port 1; port 0 is granted only after data strobes drop.
- Timeout: TIMEOUT_CYCLES=8, data_read with no memory_response -> strobes drop after 8 ISSUE cycles; data_read_data=0xDEADBEEF; bus_error and data_response pulse in the same cycle.
- Reset mid-ISSUE: assert reset with memory_read high -> all outputs 0 immediately (asynchronously). After release, a new inst_read completes normally, with port 0 winning any tie.

Source files
------------

// File: rtl/memory_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the two-port memory bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface memory_bus_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 inst_read;
  logic [BUS_WIDTH-1:0] inst_address;
  logic [BUS_WIDTH-1:0] inst_read_data;
  logic                 inst_response;

  logic                 data_read;
  logic                 data_write;
  logic [BUS_WIDTH-1:0] data_address;
  logic [BUS_WIDTH-1:0] data_write_data;
  logic [BUS_WIDTH-1:0] data_read_data;
  logic                 data_response;

  logic                 memory_read;
  logic                 memory_write;
  logic [BUS_WIDTH-1:0] memory_address;
  logic [BUS_WIDTH-1:0] memory_write_data;
  logic [BUS_WIDTH-1:0] memory_read_data;
  logic                 memory_response;

  logic                 bus_error;
  logic                 busy;

  modport slave (
    input  inst_read, inst_address,
    output inst_read_data, inst_response,
    input  data_read, data_write, data_address, data_write_data,
    output data_read_data, data_response,
    output memory_read, memory_write, memory_address, memory_write_data,
    input  memory_read_data, memory_response,
    output bus_error, busy
  );

  modport master (
    output inst_read, inst_address,
    input  inst_read_data, inst_response,
    output data_read, data_write, data_address, data_write_data,
    input  data_read_data, data_response,
    input  memory_read, memory_write, memory_address, memory_write_data,
    output memory_read_data, memory_response,
    input  bus_error, busy
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Arbitrates instruction-fetch (port 0) and data (port 1) requesters onto one memory port,
// with registered downstream strobes, per-port read data, and a timeout watchdog.
module memory_bus_arbiter #(
  parameter int                   BUS_WIDTH      = 32,
  parameter int                   PRIORITY_MODE  = 0,
  parameter int                   TIMEOUT_CYCLES = 1024,
  parameter logic [BUS_WIDTH-1:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  memory_bus_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  state_t               state_q;
  logic                 last_grant_q;
  logic                 port_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [BUS_WIDTH-1:0] inst_rdata_q;
  logic [BUS_WIDTH-1:0] data_rdata_q;
  logic                 inst_resp_q;
  logic                 data_resp_q;
  logic                 bus_error_q;

  logic                 req0_d;
  logic                 req1_d;
  logic                 grant_port_d;
  logic                 done_d;
  logic [BUS_WIDTH-1:0] rdata_d;

  always_comb begin
    req0_d = bus.inst_read;
    req1_d = bus.data_read | bus.data_write;
    // On a tie, round-robin hands the grant to whichever port did not win last time.
    grant_port_d = req1_d & (~req0_d | (PRIORITY_MODE == 1) | ~last_grant_q);
    done_d  = bus.memory_response | (cnt_q == CNT_LAST);
    rdata_d = bus.memory_response ? bus.memory_read_data : ERROR_DATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_resp_q  <= 1'b0;
      data_resp_q  <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      inst_resp_q <= 1'b0;
      data_resp_q <= 1'b0;
      bus_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0_d | req1_d) begin
            port_q       <= grant_port_d;
            last_grant_q <= grant_port_d;
            cnt_q        <= '0;
            state_q      <= ISSUE;
            if (grant_port_d) begin
              addr_q      <= bus.data_address;
              wdata_q     <= bus.data_write_data;
              mem_write_q <= bus.data_write;
              mem_read_q  <= ~bus.data_write;
            end else begin
              addr_q      <= bus.inst_address;
              mem_write_q <= 1'b0;
              mem_read_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (done_d) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            bus_error_q <= ~bus.memory_response;
            state_q     <= RESPOND;
            if (port_q) begin
              data_resp_q <= 1'b1;
              if (mem_read_q) data_rdata_q <= rdata_d;
            end else begin
              inst_resp_q <= 1'b1;
              if (mem_read_q) inst_rdata_q <= rdata_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inst_read_data    = inst_rdata_q;
  assign bus.inst_response     = inst_resp_q;
  assign bus.data_read_data    = data_rdata_q;
  assign bus.data_response     = data_resp_q;
  assign bus.memory_read       = mem_read_q;
  assign bus.memory_write      = mem_write_q;
  assign bus.memory_address    = addr_q;
  assign bus.memory_write_data = wdata_q;
  assign bus.bus_error         = bus_error_q;
  assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench: a round-robin arbiter and a fixed-priority arbiter, each with a small
// memory responder that answers one cycle after a strobe rises when enabled.
module tb_memory_bus_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic        mem_en0, mem_en1;
  logic [31:0] mem_rdata0, mem_rdata1;

  memory_bus_arbiter_if #(.BUS_WIDTH(32)) b0 ();
  memory_bus_arbiter_if #(.BUS_WIDTH(32)) b1 ();

  memory_bus_arbiter #(.BUS_WIDTH(32), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8),
                       .ERROR_DATA(32'hDEADBEEF))
    u_rr (.clk(clk), .reset(reset), .bus(b0));

  memory_bus_arbiter #(.BUS_WIDTH(32), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8),
                       .ERROR_DATA(32'hDEADBEEF))
    u_fx (.clk(clk), .reset(reset), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    b0.memory_response  <= mem_en0 && (b0.memory_read || b0.memory_write) && !b0.memory_response;
    b0.memory_read_data <= mem_rdata0;
    b1.memory_response  <= mem_en1 && (b1.memory_read || b1.memory_write) && !b1.memory_response;
    b1.memory_read_data <= mem_rdata1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    mem_en0 = 1'b1; mem_en1 = 1'b1;
    mem_rdata0 = '0; mem_rdata1 = '0;
    b0.inst_read = 0; b0.inst_address = '0; b0.data_read = 0; b0.data_write = 0;
    b0.data_address = '0; b0.data_write_data = '0;
    b1.inst_read = 0; b1.inst_address = '0; b1.data_read = 0; b1.data_write = 0;
    b1.data_address = '0; b1.data_write_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", b0.busy, 0);
    chk("rst_mem_read", b0.memory_read, 0);
    chk("rst_mem_write", b0.memory_write, 0);
    chk("rst_mem_addr", b0.memory_address, 0);
    chk("rst_mem_wdata", b0.memory_write_data, 0);
    chk("rst_inst_rdata", b0.inst_read_data, 0);
    chk("rst_data_rdata", b0.data_read_data, 0);
    chk("rst_responses", {b0.inst_response, b0.data_response, b0.bus_error}, 0);
    chk("rst_fx_busy", b1.busy, 0);
    reset = 1'b0;
    tick();

    // Single fetch
    b0.inst_read = 1; b0.inst_address = 32'h100; mem_rdata0 = 32'h00000013;
    tick();
    chk("fetch_strobe", {b0.memory_read, b0.memory_write}, 2'b10);
    chk("fetch_addr", b0.memory_address, 32'h100);
    chk("fetch_busy", b0.busy, 1);
    tick();
    chk("fetch_no_early_resp", b0.inst_response, 0);
    tick();
    chk("fetch_resp", b0.inst_response, 1);
    chk("fetch_rdata", b0.inst_read_data, 32'h00000013);
    chk("fetch_other_resp", b0.data_response, 0);
    chk("fetch_strobe_drop", b0.memory_read, 0);
    b0.inst_read = 0;
    tick();
    chk("fetch_resp_one_cycle", b0.inst_response, 0);
    chk("fetch_idle", b0.busy, 0);

    // Data write
    b0.data_write = 1; b0.data_address = 32'h2000; b0.data_write_data = 32'hCAFEBABE;
    mem_rdata0 = 32'h11111111;
    tick();
    chk("wr_strobe", {b0.memory_read, b0.memory_write}, 2'b01);
    chk("wr_addr", b0.memory_address, 32'h2000);
    chk("wr_wdata", b0.memory_write_data, 32'hCAFEBABE);
    tick();
    tick();
    chk("wr_resp", {b0.inst_response, b0.data_response}, 2'b01);
    chk("wr_rdata_unchanged", b0.data_read_data, 0);
    b0.data_write = 0;
    tick();
    chk("wr_resp_one_cycle", b0.data_response, 0);

    // Timeout on a data read
    mem_en0 = 0;
    b0.data_read = 1; b0.data_address = 32'h3000;
    for (int i = 0; i < 8; i++) tick();
    chk("to_strobe_held_8", b0.memory_read, 1);
    chk("to_no_early_err", b0.bus_error, 0);
    tick();
    chk("to_strobe_drop", b0.memory_read, 0);
    chk("to_err_and_resp", {b0.bus_error, b0.data_response}, 2'b11);
    chk("to_rdata", b0.data_read_data, 32'hDEADBEEF);
    chk("to_inst_rdata_stable", b0.inst_read_data, 32'h00000013);
    b0.data_read = 0;
    tick();
    chk("to_err_one_cycle", b0.bus_error, 0);

    // Reset while a fetch is stuck in ISSUE
    b0.inst_read = 1; b0.inst_address = 32'h400;
    tick();
    chk("mid_strobe", b0.memory_read, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_read", b0.memory_read, 0);
    chk("async_busy", b0.busy, 0);
    chk("async_addr", b0.memory_address, 0);
    chk("async_rdata", {b0.inst_read_data, b0.data_read_data} == 64'd0, 1);
    tick();
    reset = 1'b0;
    mem_en0 = 1; mem_rdata0 = 32'h0BADF00D;
    b0.data_read = 1; b0.data_address = 32'h500;

    // Round-robin tie, port 0 first after reset
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_addr", b0.memory_address, (k % 2 == 0) ? 32'h400 : 32'h500);
      tick();
      tick();
      chk("rr_grant", {b0.inst_response, b0.data_response}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k == 0) chk("rr_first_rdata", b0.inst_read_data, 32'h0BADF00D);
      tick();
    end
    b0.inst_read = 0; b0.data_read = 0;

    // Fixed priority: data port wins every tie
    b1.inst_read = 1; b1.inst_address = 32'h600;
    b1.data_read = 1; b1.data_address = 32'h700;
    mem_rdata1 = 32'h5A5A5A5A;
    for (int k = 0; k < 4; k++) begin
      tick(); tick(); tick();
      chk("fx_grant", {b1.inst_response, b1.data_response}, 2'b01);
      tick();
    end
    chk("fx_data_rdata", b1.data_read_data, 32'h5A5A5A5A);
    b1.data_read = 0;
    tick();
    chk("fx_port0_addr", b1.memory_address, 32'h600);
    tick(); tick();
    chk("fx_port0_grant", {b1.inst_response, b1.data_response}, 2'b10);
    b1.inst_read = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
